// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding and mode constants for the serial ALU stages
package alu_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational full adder built from two half adders and an OR
module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  logic w_hs, w_hc, w_cc;
  assign w_hs   = i_a ^ i_b;
  assign w_hc   = i_a & i_b;
  assign o_sum  = w_hs ^ i_cin;
  assign w_cc   = w_hs & i_cin;
  assign o_cout = w_hc | w_cc;
endmodule

// File: rtl/serial_addsub6.sv
// serial_addsub6: bit-serial two's-complement add/subtract, LSB first, one full-adder cell
module serial_addsub6
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             carryOut,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             w_sum, w_cout;
  logic [WIDTH-1:0] w_res_next;
  serial_fa_cell u_fa (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );
  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};
  // control FSM: load operands, shift one bit per clock, publish result and flags on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      s        <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_a     <= a;
          r_b     <= (mode == MODE_SUB) ? ~b : b;
          r_carry <= (mode != MODE_ADD);
          r_cnt   <= '0;
          busy    <= 1'b1;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next;
          r_carry <= w_cout;
          if (r_cnt == CW'(WIDTH - 1)) begin
            s        <= w_res_next;
            carryOut <= w_cout;
            overflow <= r_carry ^ w_cout;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub6.sv
// tb_serial_addsub6: directed plus random checks of serial_addsub6 against an arithmetic model
module tb_serial_addsub6;
  logic       clk = 1'b0;
  logic       rst, start, mode;
  logic [5:0] a, b;
  logic       busy, done, carryOut, overflow;
  logic [5:0] s;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [5:0] last_s = '0;

  serial_addsub6 #(.WIDTH(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .s       (s),
    .carryOut(carryOut),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // returns {overflow, carryOut, s} from plain integer arithmetic
  function automatic logic [7:0] model(input logic m, input logic [5:0] x, input logic [5:0] y);
    int sx, sy, r, u;
    logic ov, co;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = m ? sx - sy : sx + sy;
    u  = m ? int'(x) + 64 - int'(y) : int'(x) + int'(y);
    ov = (r < -32) || (r > 31);
    co = (u >= 64);
    return {ov, co, u[5:0]};
  endfunction

  task automatic run_op(input logic m, input logic [5:0] x, input logic [5:0] y, input bit inj, input string tag);
    logic [7:0] e;
    int cyc;
    e = model(m, x, y);
    @(negedge clk);
    start = 1'b1; mode = m; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); a = 6'($urandom); b = 6'($urandom);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 3) begin
        chk({tag, "_hold"}, 32'(s), 32'(last_s));
        if (inj) begin start = 1'b1; mode = ~m; a = ~x; b = 6'd1; end
      end
      if (cyc == 4) start = 1'b0;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd7);
    chk({tag, "_s"}, 32'(s), 32'(e[5:0]));
    chk({tag, "_co"}, 32'(carryOut), 32'(e[6]));
    chk({tag, "_ov"}, 32'(overflow), 32'(e[7]));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    last_s = e[5:0];
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_co", 32'(carryOut), 32'd0);
    chk("rst_ov", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 6'b000101, 6'b000011, 1'b0, "add5_3");
    run_op(1'b1, 6'b000101, 6'b000011, 1'b0, "sub5_3");
    run_op(1'b1, 6'b000011, 6'b000101, 1'b0, "sub3_5");
    run_op(1'b0, 6'b011111, 6'b000001, 1'b0, "add_ovf");
    run_op(1'b1, 6'b100000, 6'b000001, 1'b0, "sub_ovf");
    run_op(1'b1, 6'b000000, 6'b100000, 1'b0, "neg_min");
    for (int i = 0; i < 40; i++)
      run_op(1'($urandom), 6'($urandom), 6'($urandom), 1'b0, "rand");
    run_op(1'b0, 6'b000101, 6'b000011, 1'b1, "ignore");
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 6'd9; b = 6'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_co", 32'(carryOut), 32'd0);
    chk("abort_ov", 32'(overflow), 32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
